// File: rtl/bakraid_textarb_pkg.sv
// Shared types and defaults for the Bakraid text ROM arbiter.
// Used by bakraid_textarb_tagpipe and bakraid_textrom_arbiter.
package bakraid_textarb_pkg;

  localparam int TEXTROM_AW  = 14;
  localparam int TEXTROM_DW  = 16;
  localparam int TEXTROM_LAT = 2;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bakraid_textarb_tagpipe.sv
// In-flight owner tag delay line. The head stage lines up with MEM_CS and the
// tail stage lines up with the cycle in which MEM_DATA is valid.
module bakraid_textarb_tagpipe
  import bakraid_textarb_pkg::*;
#(
  parameter int DEPTH = TEXTROM_LAT + 1
) (
  input  logic CLK96,
  input  logic RESET96,
  input  tag_t tag_in,
  output tag_t tag_out
);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      tag_t q_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge CLK96 or posedge RESET96) begin
          if (RESET96) q_reg <= '0;
          else         q_reg <= tag_in;
        end
      end else begin : g_tail
        always_ff @(posedge CLK96 or posedge RESET96) begin
          if (RESET96) q_reg <= '0;
          else         q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign tag_out = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/bakraid_textrom_arbiter.sv
// Round-robin arbiter sharing one text ROM read port between the extratext (A)
// and text-layer (B) renderers, with 2-word bursts. Optional counters: BAKRAID_TEXTROM_ARB_STATS_EN.
module bakraid_textrom_arbiter
  import bakraid_textarb_pkg::*;
#(
  parameter int AW  = TEXTROM_AW,
  parameter int DW  = TEXTROM_DW,
  parameter int LAT = TEXTROM_LAT
) (
  input  logic          CLK96,
  input  logic          RESET96,
  input  logic          A_REQ,
  input  logic [AW-1:0] A_ADDR,
  input  logic          A_BURST,
  output logic          A_ACK,
  output logic [DW-1:0] A_DATA,
  output logic          A_DVALID,
  input  logic          B_REQ,
  input  logic [AW-1:0] B_ADDR,
  input  logic          B_BURST,
  output logic          B_ACK,
  output logic [DW-1:0] B_DATA,
  output logic          B_DVALID,
  output logic          MEM_CS,
  output logic [AW-1:0] MEM_ADDR,
  input  logic [DW-1:0] MEM_DATA
`ifdef BAKRAID_TEXTROM_ARB_STATS_EN
  ,
  input  logic          STAT_CLR,
  output logic [15:0]   STAT_A_WORDS,
  output logic [15:0]   STAT_B_WORDS,
  output logic [15:0]   STAT_CONFLICTS
`endif
);

  arb_state_t    state_reg, state_next;
  req_id_t       rr_last_reg, rr_last_next;
  req_id_t       owner_reg, owner_next;
  logic [AW-1:0] burst_addr_reg, burst_addr_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic          mem_cs_reg, mem_cs_next;
  logic [DW-1:0] a_data_reg, b_data_reg;
  logic          a_dvalid_reg, b_dvalid_reg;
  logic          grant_valid, both_req;
  req_id_t       grant_id;
  tag_t          tag_next, tag_out;

  always_comb begin
    state_next      = state_reg;
    rr_last_next    = rr_last_reg;
    owner_next      = owner_reg;
    burst_addr_next = burst_addr_reg;
    mem_cs_next     = 1'b0;
    mem_addr_next   = mem_addr_reg;
    tag_next        = '0;
    grant_valid     = 1'b0;
    grant_id        = REQ_A;
    both_req        = A_REQ && B_REQ;
    case (state_reg)
      ARB: begin
        if (!RESET96 && (A_REQ || B_REQ)) begin
          grant_valid = 1'b1;
          if (both_req) grant_id = (rr_last_reg == REQ_B) ? REQ_A : REQ_B;
          else          grant_id = A_REQ ? REQ_A : REQ_B;
          rr_last_next  = grant_id;
          mem_cs_next   = 1'b1;
          mem_addr_next = (grant_id == REQ_A) ? A_ADDR : B_ADDR;
          tag_next      = '{valid: 1'b1, id: grant_id};
          if ((grant_id == REQ_A) ? A_BURST : B_BURST) begin
            state_next      = HOLD;
            burst_addr_next = mem_addr_next;
            owner_next      = grant_id;
          end
        end
      end
      HOLD: begin
        // Second beat; the address increment wraps naturally at AW bits.
        mem_cs_next   = 1'b1;
        mem_addr_next = burst_addr_reg + {{(AW-1){1'b0}}, 1'b1};
        tag_next      = '{valid: 1'b1, id: owner_reg};
        state_next    = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      state_reg      <= ARB;
      rr_last_reg    <= REQ_B;
      owner_reg      <= REQ_A;
      burst_addr_reg <= '0;
      mem_cs_reg     <= 1'b0;
      mem_addr_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      rr_last_reg    <= rr_last_next;
      owner_reg      <= owner_next;
      burst_addr_reg <= burst_addr_next;
      mem_cs_reg     <= mem_cs_next;
      mem_addr_reg   <= mem_addr_next;
    end
  end

  bakraid_textarb_tagpipe #(.DEPTH(LAT + 1)) u_tagpipe (
    .CLK96   (CLK96),
    .RESET96 (RESET96),
    .tag_in  (tag_next),
    .tag_out (tag_out)
  );

  // Returned data is registered towards its owner; DATA holds between words.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      a_data_reg   <= '0;
      b_data_reg   <= '0;
      a_dvalid_reg <= 1'b0;
      b_dvalid_reg <= 1'b0;
    end else begin
      a_dvalid_reg <= tag_out.valid && (tag_out.id == REQ_A);
      b_dvalid_reg <= tag_out.valid && (tag_out.id == REQ_B);
      if (tag_out.valid && (tag_out.id == REQ_A)) a_data_reg <= MEM_DATA;
      if (tag_out.valid && (tag_out.id == REQ_B)) b_data_reg <= MEM_DATA;
    end
  end

  assign A_ACK    = grant_valid && (grant_id == REQ_A);
  assign B_ACK    = grant_valid && (grant_id == REQ_B);
  assign A_DATA   = a_data_reg;
  assign B_DATA   = b_data_reg;
  assign A_DVALID = a_dvalid_reg;
  assign B_DVALID = b_dvalid_reg;
  assign MEM_CS   = mem_cs_reg;
  assign MEM_ADDR = mem_addr_reg;

`ifdef BAKRAID_TEXTROM_ARB_STATS_EN
  logic [15:0] stat_a_reg, stat_b_reg, stat_conf_reg;

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      stat_a_reg    <= '0;
      stat_b_reg    <= '0;
      stat_conf_reg <= '0;
    end else if (STAT_CLR) begin
      stat_a_reg    <= '0;
      stat_b_reg    <= '0;
      stat_conf_reg <= '0;
    end else begin
      if (tag_next.valid && (tag_next.id == REQ_A)) stat_a_reg <= sat_inc16(stat_a_reg);
      if (tag_next.valid && (tag_next.id == REQ_B)) stat_b_reg <= sat_inc16(stat_b_reg);
      if ((state_reg == ARB) && both_req) stat_conf_reg <= sat_inc16(stat_conf_reg);
    end
  end

  assign STAT_A_WORDS   = stat_a_reg;
  assign STAT_B_WORDS   = stat_b_reg;
  assign STAT_CONFLICTS = stat_conf_reg;
`endif

endmodule

// File: tb/tb_bakraid_textrom_arbiter.sv
// Scoreboard bench for bakraid_textrom_arbiter: a grant model pushes expected words,
// a separate monitor pops them as DVALIDs appear.
module tb_bakraid_textrom_arbiter;

  localparam int AW  = 14;
  localparam int DW  = 16;
  localparam int LAT = 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          CLK96 = 1'b0;
  logic          RESET96 = 1'b1;
  logic          A_REQ = 1'b0, B_REQ = 1'b0;
  logic [AW-1:0] A_ADDR = '0, B_ADDR = '0;
  logic          A_BURST = 1'b0, B_BURST = 1'b0;
  logic          A_ACK, B_ACK, A_DVALID, B_DVALID, MEM_CS;
  logic [DW-1:0] A_DATA, B_DATA, MEM_DATA;
  logic [AW-1:0] MEM_ADDR;
`ifdef BAKRAID_TEXTROM_ARB_STATS_EN
  logic          STAT_CLR = 1'b0;
  logic [15:0]   STAT_A_WORDS, STAT_B_WORDS, STAT_CONFLICTS;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic hold_m = 1'b0;
  logic last_b_m = 1'b1;
  int   words_a_m = 0, words_b_m = 0, conf_m = 0;

  always #5 CLK96 = ~CLK96;
  always @(posedge CLK96) cyc <= cyc + 1;

  bakraid_textrom_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .CLK96    (CLK96),
    .RESET96  (RESET96),
    .A_REQ    (A_REQ),
    .A_ADDR   (A_ADDR),
    .A_BURST  (A_BURST),
    .A_ACK    (A_ACK),
    .A_DATA   (A_DATA),
    .A_DVALID (A_DVALID),
    .B_REQ    (B_REQ),
    .B_ADDR   (B_ADDR),
    .B_BURST  (B_BURST),
    .B_ACK    (B_ACK),
    .B_DATA   (B_DATA),
    .B_DVALID (B_DVALID),
    .MEM_CS   (MEM_CS),
    .MEM_ADDR (MEM_ADDR),
    .MEM_DATA (MEM_DATA)
`ifdef BAKRAID_TEXTROM_ARB_STATS_EN
    ,
    .STAT_CLR       (STAT_CLR),
    .STAT_A_WORDS   (STAT_A_WORDS),
    .STAT_B_WORDS   (STAT_B_WORDS),
    .STAT_CONFLICTS (STAT_CONFLICTS)
`endif
  );

  // Injective ROM contents so any address slip shows up as a data error.
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return {a[7:0], 2'b01, a[13:8]} ^ 16'h5A3C;
  endfunction

  // ROM with LAT cycles of read latency; junk when no read is due.
  logic          rom_v [LAT];
  logic [DW-1:0] rom_d [LAT];
  always @(posedge CLK96) begin
    rom_v[0] <= MEM_CS;
    rom_d[0] <= rom(MEM_ADDR);
    for (int i = 1; i < LAT; i++) begin
      rom_v[i] <= rom_v[i-1];
      rom_d[i] <= rom_d[i-1];
    end
  end
  assign MEM_DATA = (rom_v[LAT-1] === 1'b1) ? rom_d[LAT-1] : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic id_b, input logic [AW-1:0] a, input int due);
    exp_t e;
    e.addr = a;
    e.data = rom(a);
    e.due  = due;
    if (id_b) qb.push_back(e);
    else      qa.push_back(e);
  endtask

  // One arbitration cycle: model decides who should be granted, compares both
  // ACKs, queues the expected words, then returns just after the next edge.
  task automatic step(output logic ea, output logic eb);
    logic [AW-1:0] a0;
    logic          bst;
    int            c;
    @(negedge CLK96);
    c  = cyc;
    ea = 1'b0;
    eb = 1'b0;
    if (hold_m) hold_m = 1'b0;
    else if (A_REQ && B_REQ) begin
      conf_m++;
      if (last_b_m) ea = 1'b1;
      else          eb = 1'b1;
    end else if (A_REQ) ea = 1'b1;
    else if (B_REQ)     eb = 1'b1;
    chk("a_ack", 32'(A_ACK), 32'(ea));
    chk("b_ack", 32'(B_ACK), 32'(eb));
    if (ea || eb) begin
      a0       = ea ? A_ADDR : B_ADDR;
      bst      = ea ? A_BURST : B_BURST;
      last_b_m = eb;
      hold_m   = bst;
      push(eb, a0, c + LAT + 2);
      if (bst) push(eb, a0 + 14'd1, c + LAT + 3);
      if (eb) words_b_m += bst ? 2 : 1;
      else    words_a_m += bst ? 2 : 1;
      $display("cyc %0d grant %s addr=%h burst=%0d", c, eb ? "B" : "A", a0, bst);
    end
    @(posedge CLK96);
    #1;
  endtask

  task automatic mon(input logic id_b, input logic dv, input logic [DW-1:0] d,
                     inout logic [DW-1:0] last);
    exp_t e;
    int   n;
    n = id_b ? qb.size() : qa.size();
    if (dv) begin
      if (n == 0) begin
        if (id_b) chk("b_spurious_dvalid", 32'(dv), 32'(0));
        else      chk("a_spurious_dvalid", 32'(dv), 32'(0));
      end else begin
        if (id_b) e = qb.pop_front();
        else      e = qa.pop_front();
        chk("rdata", 32'(d), 32'(e.data));
        chk("rlatency", 32'(cyc), 32'(e.due));
        $display("cyc %0d return %s addr=%h data=%h", cyc, id_b ? "B" : "A", e.addr, d);
      end
      last = d;
    end else begin
      chk("data_hold", 32'(d), 32'(last));
    end
  endtask

  initial begin : monitor
    logic [DW-1:0] la, lb;
    la = '0;
    lb = '0;
    forever begin
      @(negedge CLK96);
      if (RESET96) begin
        la = '0;
        lb = '0;
      end else begin
        mon(1'b0, A_DVALID, A_DATA, la);
        mon(1'b1, B_DVALID, B_DATA, lb);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mem_cs"},   32'(MEM_CS), 32'(0));
    chk({tag, "_mem_addr"}, 32'(MEM_ADDR), 32'(0));
    chk({tag, "_a_dvalid"}, 32'(A_DVALID), 32'(0));
    chk({tag, "_b_dvalid"}, 32'(B_DVALID), 32'(0));
    chk({tag, "_a_data"},   32'(A_DATA), 32'(0));
    chk({tag, "_b_data"},   32'(B_DATA), 32'(0));
    chk({tag, "_a_ack"},    32'(A_ACK), 32'(0));
    chk({tag, "_b_ack"},    32'(B_ACK), 32'(0));
  endtask

  initial begin : stimulus
    logic ea, eb;
    int   n;

    A_REQ = 1'b1;   // ACK must stay low while in reset
    repeat (3) @(posedge CLK96);
    #1;
    check_idle_outputs("reset");
    A_REQ = 1'b0;
    RESET96 = 1'b0;

    // Simultaneous first requests, then continuous contention.
    A_REQ = 1'b1; A_ADDR = 14'h0010;
    B_REQ = 1'b1; B_ADDR = 14'h0200;
    for (int i = 0; i < 8; i++) begin
      step(ea, eb);
      if (ea) A_ADDR = A_ADDR + 14'd1;
      if (eb) B_ADDR = B_ADDR + 14'd1;
    end
    A_REQ = 1'b0; B_REQ = 1'b0;
    repeat (6) step(ea, eb);

    // Burst at the top of the address space while B waits.
    A_REQ = 1'b1; A_BURST = 1'b1; A_ADDR = 14'h3FFF;
    B_REQ = 1'b1; B_ADDR = 14'h0555;
    step(ea, eb);
    A_REQ = 1'b0; A_BURST = 1'b0;
    chk("wrap_cs0", 32'(MEM_CS), 32'(1));
    chk("wrap_addr0", 32'(MEM_ADDR), 32'h3FFF);
    step(ea, eb);
    chk("wrap_cs1", 32'(MEM_CS), 32'(1));
    chk("wrap_addr1", 32'(MEM_ADDR), 32'h0000);
    step(ea, eb);
    if (eb) B_REQ = 1'b0;
    repeat (6) step(ea, eb);
    B_REQ = 1'b0;

    // Single A read.
    A_REQ = 1'b1; A_ADDR = 14'h0123;
    step(ea, eb);
    A_REQ = 1'b0;
    chk("single_cs", 32'(MEM_CS), 32'(1));
    chk("single_addr", 32'(MEM_ADDR), 32'h0123);
    repeat (6) step(ea, eb);

    // B streaming alone at one word per cycle.
    B_REQ = 1'b1; B_ADDR = 14'h1000;
    for (int i = 0; i < 6; i++) begin
      step(ea, eb);
      B_ADDR = B_ADDR + 14'd1;
    end
    B_REQ = 1'b0;
    repeat (6) step(ea, eb);

    // Reset one cycle after a burst grant.
    A_REQ = 1'b1; A_BURST = 1'b1; A_ADDR = 14'h1234;
    step(ea, eb);
    A_REQ = 1'b0; A_BURST = 1'b0;
    B_REQ = 1'b1; B_ADDR = 14'h0777;
    #1;
    RESET96 = 1'b1;
    #1;
    check_idle_outputs("midreset");
    qa.delete();
    qb.delete();
    hold_m = 1'b0;
    last_b_m = 1'b1;
    words_a_m = 0; words_b_m = 0; conf_m = 0;
    repeat (2) @(negedge CLK96);
    chk("reset_b_ack", 32'(B_ACK), 32'(0));
    @(posedge CLK96);
    #1;
    RESET96 = 1'b0;
    A_REQ = 1'b1; A_ADDR = 14'h0042;
    n = 0;
    while ((A_REQ || B_REQ) && n < 6) begin
      step(ea, eb);
      if (ea) A_REQ = 1'b0;
      if (eb) B_REQ = 1'b0;
      n++;
    end
    chk("post_reset_drain", 32'({A_REQ, B_REQ}), 32'(0));
    repeat (6) step(ea, eb);

    // Random traffic; a requester holds its request until acknowledged.
    for (int i = 0; i < 300; i++) begin
      step(ea, eb);
      if (!A_REQ || ea) begin
        A_REQ   = ($urandom_range(0, 3) != 0);
        A_ADDR  = 14'($urandom);
        A_BURST = ($urandom_range(0, 2) == 0);
      end
      if (!B_REQ || eb) begin
        B_REQ   = ($urandom_range(0, 3) != 0);
        B_ADDR  = 14'($urandom);
        B_BURST = ($urandom_range(0, 2) == 0);
      end
    end
    n = 0;
    while ((A_REQ || B_REQ) && n < 8) begin
      step(ea, eb);
      if (ea) A_REQ = 1'b0;
      if (eb) B_REQ = 1'b0;
      n++;
    end
    A_REQ = 1'b0; B_REQ = 1'b0;
    repeat (LAT + 6) step(ea, eb);
    chk("a_queue_empty", 32'(qa.size()), 32'(0));
    chk("b_queue_empty", 32'(qb.size()), 32'(0));

`ifdef BAKRAID_TEXTROM_ARB_STATS_EN
    chk("stat_a_words", 32'(STAT_A_WORDS), 32'(words_a_m));
    chk("stat_b_words", 32'(STAT_B_WORDS), 32'(words_b_m));
    chk("stat_conflicts", 32'(STAT_CONFLICTS), 32'(conf_m));
    STAT_CLR = 1'b1;
    A_REQ = 1'b1; A_ADDR = 14'h0099;
    step(ea, eb);
    STAT_CLR = 1'b0;
    A_REQ = 1'b0;
    chk("stat_clr_a", 32'(STAT_A_WORDS), 32'(0));
    chk("stat_clr_b", 32'(STAT_B_WORDS), 32'(0));
    chk("stat_clr_conf", 32'(STAT_CONFLICTS), 32'(0));
    repeat (LAT + 4) step(ea, eb);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bakraid_textrom_arbiter.md
Name: bakraid_textrom_arbiter

Overview:
- Shares one 16-bit text ROM read port between two line renderers.
- Requester A is the extratext line renderer; requester B is the text-layer line renderer.
- Provides a REQ/ACK handshake, round-robin arbitration, and 2-word bursts so a renderer can fetch one 32-bit tile row as 2 beats.
- Sits in the CLK96 domain between the renderers and the ROM/SDRAM-slot read port. Returned data is steered to its owner through an in-flight tag pipeline.

Parameters:
- AW, 14, ROM word address width.
- DW, 16, ROM data width.
- LAT, 2, cycles from MEM_CS to MEM_DATA valid. Range 1..8.

Ports:
- CLK96  in  1  system clock.
- RESET96  in  1  reset: asynchronous, active-high.
- A_REQ  in  1  requester A read request. Held with A_ADDR/A_BURST stable until A_ACK.
- A_ADDR  in  AW  requester A word address.
- A_BURST  in  1  fetch A_ADDR and A_ADDR+1.
- A_ACK  out  1  combinational grant pulse to A.
- A_DATA  out  DW  returned word for A.
- A_DVALID  out  1  A_DATA valid, one cycle per word.
- B_REQ, B_ADDR, B_BURST, B_ACK, B_DATA, B_DVALID: same as the A ports, for requester B.
- MEM_CS  out  1  registered read strobe.
- MEM_ADDR  out  AW  registered read address.
- MEM_DATA  in  DW  ROM data, valid LAT cycles after MEM_CS.

Behaviour:
- Reset (async, any time, including mid-burst): MEM_CS=0, MEM_ADDR=0, A/B_DATA=0, A/B_DVALID=0, FSM=ARB, rr_last=B, tag pipeline cleared. In-flight data is discarded; no DVALID appears after reset.
- ACK outputs are combinational. They are 0 while RESET96 is high and 0 in the HOLD state.
- FSM states: ARB, HOLD.
- ARB, exactly one REQ high: grant it.
- ARB, both REQ high: grant the requester not equal to rr_last.
- ARB, on any grant:
  - ACK=1 for that requester in cycle t; rr_last updated.
  - Cycle t+1: MEM_CS=1, MEM_ADDR=granted addr, tag={valid,id}.
  - If BURST=1: next state HOLD, burst addr latched.
- ARB, no REQ: MEM_CS=0 next cycle.
- HOLD (cycle t+1):
  - No ACK to anyone.
  - Cycle t+2: MEM_CS=1, MEM_ADDR=latched addr+1, modulo 2^AW (0x3FFF wraps to 0x0000).
  - Same owner tag; return to ARB.
- Requester handshake: after ACK the requester drops REQ or presents a new address at the next edge. A requester holding REQ continuously gets one grant per cycle when alone (throughput 1 word/cycle, bursts included).
- Return path:
  - Tag pipeline is LAT+1 stages deep.
  - In cycle t+1+LAT (MEM_DATA valid), the owner's DATA <= MEM_DATA and DVALID <= 1 are registered, visible in cycle t+2+LAT.
  - ACK-to-DVALID latency = LAT+2 cycles. Burst beats return on consecutive cycles, in order.
  - DATA holds its last value when DVALID=0.
- Fairness: under continuous contention, grants alternate A,B,A,B. A burst counts as one grant. Maximum wait for either requester is one competing grant (≤2 cycles for a burst).
- No back-pressure on the return path; requesters must accept DVALID unconditionally.

Optional Feature:
- Macro: BAKRAID_TEXTROM_ARB_STATS_EN.
- With the macro, adds outputs STAT_A_WORDS[15:0], STAT_B_WORDS[15:0] and STAT_CONFLICTS[15:0]:
  - Saturating counters of words issued per requester, and of ARB cycles with both REQ high.
  - Counters clear on RESET96 or on new input STAT_CLR (1-cycle pulse). Clear wins over a simultaneous increment.
- Without the macro: no stat ports, no counters; behaviour otherwise identical.

Decomposition:
- Package bakraid_textarb_pkg holds:
  - requester id typedef (REQ_A=0, REQ_B=1);
  - FSM state typedef (ARB, HOLD);
  - default constants TEXTROM_AW=14, TEXTROM_DW=16, TEXTROM_LAT=2.
- One sub-module, bakraid_textarb_tagpipe: parameterised LAT+1-deep shift register of {valid,id}. Cleared by RESET96.

Test Plan:
- A_REQ only, A_ADDR=0x0123, BURST=0, LAT=2 -> A_ACK in cycle t; MEM_CS/MEM_ADDR=0x0123 in t+1; A_DVALID with ROM[0x0123] in t+4; B_DVALID never asserts.
- A and B request in the same cycle after reset (A=0x0010, B=0x0200) -> A granted first, B next cycle; continuous contention yields ACK order A,B,A,B.
- A_BURST at A_ADDR=0x3FFF while B_REQ is high -> MEM_ADDR 0x3FFF then 0x0000 on consecutive cycles; B_ACK delayed until the cycle after HOLD; two A_DVALIDs back-to-back.
- B alone, REQ held for 6 cycles with incrementing addresses -> 6 consecutive ACKs, 6 consecutive B_DVALIDs with matching data, no gaps.
- RESET96 asserted one cycle after a burst grant -> all outputs 0 immediately, no DVALID appears afterwards; the first post-reset conflict goes to A.
- Stats macro defined: 5 A words, 3 B words, 2 conflicts -> counters read 5/3/2; STAT_CLR coinciding with a grant -> counters 0.
